// File: rtl/delay_rx_buffer.sv
// delay_rx_buffer: receive end of a fixed-latency delay-line pipeline.
// Issues credits, checks arrival timing and buffers results in a FWFT FIFO.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   issue           producer injects one item; counted only when can_issue
//   can_issue       a credit is available (registered, no path from dout_ready)
//   din_valid, din  pipeline output, expected exactly DELAY cycles after issue
//   dout_valid      FIFO head valid
//   dout            FIFO head data
//   dout_ready      consumer accepts head
//   count           FIFO occupancy
//   err_credit      sticky: issue seen while can_issue was low
//   err_unexpected  sticky: din_valid differed from the expected arrival
//   err_overflow    sticky: din_valid while FIFO full and not popping
module delay_rx_buffer #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    output logic                       can_issue,
    input  logic                       din_valid,
    input  logic [WIDTH-1:0]           din,
    output logic                       dout_valid,
    output logic [WIDTH-1:0]           dout,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_credit,
    output logic                       err_unexpected,
    output logic                       err_overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [CW-1:0]    credits;
    logic [DELAY:1]   exp_sr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             acc;
    logic             pop;
    logic             full;
    logic             push_acc;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign can_issue  = (credits != '0);
    assign acc        = issue & can_issue;
    assign dout_valid = (count != '0);
    assign pop        = dout_valid & dout_ready;
    assign full       = (count == FULL);
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign push_acc   = din_valid & (~full | pop);
    assign dout       = mem[rd_ptr];

    // Credits track free FIFO slots not yet claimed by in-flight items;
    // a popped slot only becomes issuable on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= FULL;
        end else begin
            credits <= credits - CW'(acc) + CW'(pop);
        end
    end

    // exp_sr[k] is high when an item accepted k cycles ago is in the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_sr <= '0;
        end else begin
            exp_sr[1] <= acc;
            for (int k = 2; k <= DELAY; k++) begin
                exp_sr[k] <= exp_sr[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (push_acc) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            count <= count + CW'(push_acc) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_credit     <= 1'b0;
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            if (issue & ~can_issue) begin
                err_credit <= 1'b1;
            end
            if (din_valid != exp_sr[DELAY]) begin
                err_unexpected <= 1'b1;
            end
            if (din_valid & full & ~pop) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_rx_buffer.sv
// Bench for delay_rx_buffer: three parameterisations, directed vectors,
// a queue-based reference model compared every cycle, plus literal checks.
module tb_delay_rx_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [2:0] r = '0;
    logic [2:0] iss = '0;
    logic [2:0] rdy = '0;
    logic [2:0] inj = '0;
    logic [2:0] inj_v = '0;
    logic [7:0] inj_d [3] = '{default: 8'h00};

    logic [2:0] o_ci, o_dv, o_ec, o_eu, o_eo;
    logic [7:0] o_dout [3];
    logic [7:0] o_cnt [3];

    task automatic chk(input int inst, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL u%0d.%s got=%0h want=%0h", inst, nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int D = (g == 0) ? 3 : (g == 1) ? 2 : 1;
        localparam int N = (g == 0) ? 5 : (g == 1) ? 4 : 2;
        localparam int CW = $clog2(N + 1);

        logic can_issue, dout_valid;
        logic err_credit, err_unexpected, err_overflow;
        logic [7:0] dout;
        logic [CW-1:0] count;
        logic pipe_v [1:D] = '{default: 1'b0};
        logic [7:0] pipe_d [1:D] = '{default: 8'h00};
        logic [7:0] seq = 8'(16 + 48 * g);
        logic din_valid_w;
        logic [7:0] din_w;

        assign din_valid_w = inj[g] ? inj_v[g] : pipe_v[D];
        assign din_w = inj[g] ? inj_d[g] : pipe_d[D];

        delay_rx_buffer #(.WIDTH(8), .DELAY(D), .DEPTH(N)) dut (
            .clk(clk),
            .rst(r[g]),
            .issue(iss[g]),
            .can_issue(can_issue),
            .din_valid(din_valid_w),
            .din(din_w),
            .dout_valid(dout_valid),
            .dout(dout),
            .dout_ready(rdy[g]),
            .count(count),
            .err_credit(err_credit),
            .err_unexpected(err_unexpected),
            .err_overflow(err_overflow)
        );

        assign o_ci[g] = can_issue;
        assign o_dv[g] = dout_valid;
        assign o_ec[g] = err_credit;
        assign o_eu[g] = err_unexpected;
        assign o_eo[g] = err_overflow;
        assign o_dout[g] = dout;
        assign o_cnt[g] = 8'(count);

        // Producer: a delay line of D stages tagging items with seq.
        always @(posedge clk) begin
            if (r[g]) begin
                for (int k = 1; k <= D; k++) begin
                    pipe_v[k] <= 1'b0;
                    pipe_d[k] <= 8'h00;
                end
            end else begin
                pipe_v[1] <= iss[g] & can_issue;
                pipe_d[1] <= seq;
                if (iss[g] & can_issue) seq <= seq + 8'd1;
                for (int k = 2; k <= D; k++) begin
                    pipe_v[k] <= pipe_v[k-1];
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
        end

        // Reference model: credit count, data queue, due-cycle queue.
        int m_cred = N;
        logic [7:0] q [$];
        int due [$];
        int cyc = 0;
        bit mc = 0, mu = 0, mo = 0, started = 0;

        always @(posedge clk) begin
            bit can, acc, pop, expd, in_v;
            if (r[g]) begin
                m_cred = N;
                q.delete();
                due.delete();
                mc = 0;
                mu = 0;
                mo = 0;
                started = 1;
            end else if (started) begin
                in_v = din_valid_w;
                can = (m_cred > 0);
                acc = iss[g] && can;
                if (iss[g] && !can) mc = 1;
                pop = (q.size() > 0) && rdy[g];
                expd = (due.size() > 0) && (due[0] == cyc);
                if (expd) void'(due.pop_front());
                if (in_v != expd) mu = 1;
                if (pop) void'(q.pop_front());
                if (in_v) begin
                    if (q.size() < N) q.push_back(din_w);
                    else mo = 1;
                end
                m_cred = m_cred - int'(acc) + int'(pop);
                if (acc) due.push_back(cyc + D);
            end
            cyc++;
        end

        always @(negedge clk) begin
            if (started) begin
                chk(g, "can_issue", can_issue, m_cred > 0);
                chk(g, "count", count, q.size());
                chk(g, "dout_valid", dout_valid, q.size() > 0);
                if (q.size() > 0) chk(g, "dout", dout, q[0]);
                chk(g, "err_credit", err_credit, mc);
                chk(g, "err_unexpected", err_unexpected, mu);
                chk(g, "err_overflow", err_overflow, mo);
            end
        end
    end

    initial begin
        logic [5:0] dvs;
        logic [7:0] dtag, etag, cmax;
        int low, pops, bad, acc_n;

        r = 3'b111;
        tick();
        tick();
        r = '0;
        for (int i = 0; i < 3; i++) begin
            chk(i, "rst_can_issue", o_ci[i], 1);
            chk(i, "rst_count", o_cnt[i], 0);
            chk(i, "rst_dout_valid", o_dv[i], 0);
            chk(i, "rst_dout", o_dout[i], 0);
            chk(i, "rst_errs", {o_ec[i], o_eu[i], o_eo[i]}, 0);
        end

        // Single item through DELAY=3, DEPTH=5.
        iss[0] = 1;
        rdy[0] = 1;
        tick();
        iss[0] = 0;
        dvs = '0;
        dtag = '0;
        cmax = '0;
        for (int k = 1; k <= 6; k++) begin
            dvs = {dvs[4:0], o_dv[0]};
            if (o_dv[0]) dtag = o_dout[0];
            if (o_cnt[0] > cmax) cmax = o_cnt[0];
            tick();
        end
        chk(0, "t1_dv_cycles", dvs, 6'b000100);
        chk(0, "t1_data", dtag, 8'h10);
        chk(0, "t1_cnt_max", cmax, 1);
        chk(0, "t1_errs", {o_ec[0], o_eu[0], o_eo[0]}, 0);

        // Full-rate streaming.
        iss[0] = 1;
        low = 0;
        pops = 0;
        bad = 0;
        etag = 8'h11;
        for (int k = 0; k < 30; k++) begin
            if (k == 20) iss[0] = 0;
            if (k < 20 && !o_ci[0]) low++;
            if (o_dv[0]) begin
                pops++;
                if (o_dout[0] !== etag) bad++;
                etag = etag + 8'd1;
            end
            tick();
        end
        chk(0, "t2_pops", pops, 20);
        chk(0, "t2_ci_low", low, 0);
        chk(0, "t2_order_bad", bad, 0);
        chk(0, "t2_last_tag", etag, 8'h25);

        // Unexpected arrival, then omitted arrival.
        inj[0] = 1;
        inj_v[0] = 1;
        inj_d[0] = 8'hE0;
        tick();
        inj[0] = 0;
        chk(0, "t5_inject_err", o_eu[0], 1);
        chk(0, "t5_inject_cnt", o_cnt[0], 1);
        chk(0, "t5_inject_data", o_dout[0], 8'hE0);
        tick();
        tick();
        r[0] = 1;
        tick();
        r[0] = 0;
        chk(0, "t5_err_cleared", o_eu[0], 0);
        iss[0] = 1;
        tick();
        iss[0] = 0;
        tick();
        tick();
        chk(0, "t5_before_due", o_eu[0], 0);
        inj[0] = 1;
        inj_v[0] = 0;
        tick();
        inj[0] = 0;
        chk(0, "t5_omit_err", o_eu[0], 1);
        chk(0, "t5_omit_cnt", o_cnt[0], 0);
        tick();
        r[0] = 1;
        tick();
        r[0] = 0;

        // Reset with 3 in flight and 2 buffered.
        rdy[0] = 0;
        iss[0] = 1;
        repeat (5) tick();
        iss[0] = 0;
        chk(0, "t6_pre_cnt", o_cnt[0], 2);
        chk(0, "t6_pre_ci", o_ci[0], 0);
        r[0] = 1;
        tick();
        r[0] = 0;
        chk(0, "t6_cnt", o_cnt[0], 0);
        chk(0, "t6_dv", o_dv[0], 0);
        chk(0, "t6_ci", o_ci[0], 1);
        chk(0, "t6_dout", o_dout[0], 0);
        chk(0, "t6_errs", {o_ec[0], o_eu[0], o_eo[0]}, 0);
        repeat (6) tick();
        chk(0, "t6_no_stale_cnt", o_cnt[0], 0);
        chk(0, "t6_no_stale_err", o_eu[0], 0);
        iss[0] = 1;
        acc_n = 0;
        repeat (7) begin
            if (o_ci[0]) acc_n++;
            tick();
        end
        iss[0] = 0;
        chk(0, "t6_credits", acc_n, 5);
        rdy[0] = 1;
        repeat (10) tick();

        // DELAY=2, DEPTH=4 with a stalled consumer.
        rdy[1] = 0;
        iss[1] = 1;
        acc_n = 0;
        repeat (6) begin
            if (o_ci[1]) acc_n++;
            tick();
        end
        iss[1] = 0;
        chk(1, "t3_accepted", acc_n, 4);
        chk(1, "t3_cnt", o_cnt[1], 4);
        chk(1, "t3_ci", o_ci[1], 0);
        chk(1, "t3_err_credit", o_ec[1], 1);
        chk(1, "t3_err_unexp", o_eu[1], 0);
        rdy[1] = 1;
        etag = 8'h40;
        bad = 0;
        pops = 0;
        repeat (6) begin
            if (o_dv[1]) begin
                pops++;
                if (o_dout[1] !== etag) bad++;
                etag = etag + 8'd1;
            end
            tick();
        end
        chk(1, "t3_drained", pops, 4);
        chk(1, "t3_order_bad", bad, 0);
        chk(1, "t3_end_cnt", o_cnt[1], 0);
        chk(1, "t3_end_ci", o_ci[1], 1);

        // DEPTH=2 full: push+pop, then overflow.
        rdy[2] = 0;
        iss[2] = 1;
        tick();
        tick();
        iss[2] = 0;
        tick();
        chk(2, "t4_full", o_cnt[2], 2);
        inj[2] = 1;
        inj_v[2] = 1;
        inj_d[2] = 8'hC1;
        rdy[2] = 1;
        tick();
        chk(2, "t4_pp_cnt", o_cnt[2], 2);
        chk(2, "t4_pp_ovf", o_eo[2], 0);
        chk(2, "t4_pp_head", o_dout[2], 8'h71);
        inj_d[2] = 8'hC2;
        rdy[2] = 0;
        tick();
        inj[2] = 0;
        chk(2, "t4_ovf", o_eo[2], 1);
        chk(2, "t4_ovf_cnt", o_cnt[2], 2);
        chk(2, "t4_ovf_head", o_dout[2], 8'h71);
        rdy[2] = 1;
        tick();
        chk(2, "t4_second", o_dout[2], 8'hC1);
        tick();
        chk(2, "t4_empty", o_cnt[2], 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
